// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, access-size
// codes and the read/write and boolean constants used by the memory controller.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_B = 2'b00;
    localparam logic [1:0] TYPE_H = 2'b01;
    localparam logic [1:0] TYPE_W = 2'b11;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one byte-serial memory port between the data and instruction-fetch
// requesters, with fetch anti-starvation and stale-fetch dropping on redirect.
//
// Handshake: requesters hold *_valid_i until their one-cycle completion pulse;
// controller requests stay high from grant until the matching done/ok pulse,
// with fields held constant for the whole transaction.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        d_valid_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [1:0]  d_type_i,
    output logic        d_done_o,
    output logic [31:0] d_rdata_o,
    input  logic        f_valid_i,
    input  logic [31:0] f_pc_i,
    input  logic        flush_i,
    output logic        f_ok_o,
    output logic [31:0] f_inst_o,
    output logic [31:0] f_pc_o,
    output logic        ram_r_req_o,
    output logic        ram_w_req_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    output logic [1:0]  type_o,
    output logic        inst_fe_o,
    output logic [31:0] inst_fpc_o,
    input  logic        ram_done_i,
    input  logic [31:0] ram_data_i,
    input  logic        inst_ok_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_pc_i,
    output logic [1:0]  dbg_state_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_streak;
    logic [CNT_W-1:0]   w_streak_inc;
    logic               r_drop;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [1:0]         r_type;
    logic [31:0]        r_pc;
    logic               r_d_done;
    logic [31:0]        r_d_rdata;
    logic               r_f_ok;
    logic [31:0]        r_f_inst;
    logic [31:0]        r_f_pc;
    logic               w_grant_d;
    logic               w_grant_f;

    // Data wins unless a fetch has already waited through LIMIT data grants.
    assign w_grant_d    = (r_state == ST_IDLE) & d_valid_i & (~f_valid_i | (r_streak < LIMIT));
    assign w_grant_f    = (r_state == ST_IDLE) & ~w_grant_d & f_valid_i & ~flush_i;
    assign w_streak_inc = (r_streak >= LIMIT) ? LIMIT : r_streak + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (rdy) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_next_state = ST_DATA;
                end else if (w_grant_f) begin
                    w_next_state = ST_INST;
                end
            end
            ST_DATA: if (ram_done_i) w_next_state = ST_IDLE;
            ST_INST: if (inst_ok_i) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_r_req_o = FALSE;
        ram_w_req_o = FALSE;
        inst_fe_o   = FALSE;
        // Dropping the request on the done cycle keeps the controller from
        // restarting a finished access on its idle cycle.
        if (r_state == ST_DATA && !ram_done_i) begin
            ram_r_req_o = (r_we == READ);
            ram_w_req_o = (r_we == WRITE);
        end
        if (r_state == ST_INST && !inst_ok_i) begin
            inst_fe_o = TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak  <= '0;
            r_drop    <= FALSE;
            r_we      <= READ;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_type    <= TYPE_B;
            r_pc      <= '0;
            r_d_done  <= FALSE;
            r_d_rdata <= '0;
            r_f_ok    <= FALSE;
            r_f_inst  <= '0;
            r_f_pc    <= '0;
        end else if (rdy) begin
            r_d_done <= FALSE;
            r_f_ok   <= FALSE;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_we     <= d_we_i;
                        r_addr   <= d_addr_i;
                        r_wdata  <= d_wdata_i;
                        r_type   <= d_type_i;
                        r_streak <= f_valid_i ? w_streak_inc : '0;
                    end else if (w_grant_f) begin
                        r_pc     <= f_pc_i;
                        r_streak <= '0;
                    end
                end
                ST_DATA: begin
                    if (ram_done_i) begin
                        r_d_done <= TRUE;
                        if (r_we == READ) begin
                            r_d_rdata <= ram_data_i;
                        end
                    end
                end
                ST_INST: begin
                    if (inst_ok_i) begin
                        if (!r_drop && !flush_i) begin
                            r_f_ok   <= TRUE;
                            r_f_inst <= inst_i;
                            r_f_pc   <= inst_pc_i;
                        end
                        r_drop <= FALSE;
                    end else if (flush_i) begin
                        r_drop <= TRUE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign d_done_o    = r_d_done;
    assign d_rdata_o   = r_d_rdata;
    assign f_ok_o      = r_f_ok;
    assign f_inst_o    = r_f_inst;
    assign f_pc_o      = r_f_pc;
    assign ram_addr_o  = r_addr;
    assign ram_data_o  = r_wdata;
    assign type_o      = r_type;
    assign inst_fpc_o  = r_pc;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of requesters and controller.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        d_valid_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic [1:0]  d_type_i = '0;
    logic        d_done_o;
    logic [31:0] d_rdata_o;
    logic        f_valid_i = 1'b0;
    logic [31:0] f_pc_i = '0;
    logic        flush_i = 1'b0;
    logic        f_ok_o;
    logic [31:0] f_inst_o;
    logic [31:0] f_pc_o;
    logic        ram_r_req_o;
    logic        ram_w_req_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [1:0]  type_o;
    logic        inst_fe_o;
    logic [31:0] inst_fpc_o;
    logic        ram_done_i = 1'b0;
    logic [31:0] ram_data_i = '0;
    logic        inst_ok_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_pc_i = '0;
    logic [1:0]  dbg_state;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .d_valid_i(d_valid_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_type_i(d_type_i),
        .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
        .f_valid_i(f_valid_i), .f_pc_i(f_pc_i), .flush_i(flush_i),
        .f_ok_o(f_ok_o), .f_inst_o(f_inst_o), .f_pc_o(f_pc_o),
        .ram_r_req_o(ram_r_req_o), .ram_w_req_o(ram_w_req_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .type_o(type_o),
        .inst_fe_o(inst_fe_o), .inst_fpc_o(inst_fpc_o),
        .ram_done_i(ram_done_i), .ram_data_i(ram_data_i),
        .inst_ok_i(inst_ok_i), .inst_i(inst_i), .inst_pc_i(inst_pc_i),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // transaction-level model: 0 = no transaction, 1 = data, 2 = fetch
    int          m_txn;
    int          m_streak;
    logic        m_stale;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_pc;
    logic [1:0]  m_type;
    logic        e_d_done, e_f_ok;
    logic [31:0] e_d_rdata, e_f_inst, e_f_pc;
    logic        d_fresh, f_fresh;
    logic [31:0] exp_q[$];

    // requesters and controller emulation
    logic        q_d_pend, q_d_we, q_f_pend;
    logic [31:0] q_d_addr, q_d_wdata, q_f_pc;
    logic [1:0]  q_d_type;
    int          c_lat;
    logic [31:0] c_rdata, c_inst;

    // starvation measurement from observed completions
    logic        measure = 1'b0;
    int          obs_dd = 0;
    int          last_run = -1;
    int          n_fok = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_txn = 0; m_streak = 0; m_stale = 1'b0;
        m_we = READ; m_addr = '0; m_wdata = '0; m_pc = '0; m_type = TYPE_B;
        e_d_done = 1'b0; e_f_ok = 1'b0;
        e_d_rdata = '0; e_f_inst = '0; e_f_pc = '0;
        d_fresh = 1'b0; f_fresh = 1'b0;
        exp_q.delete();
        q_d_pend = 1'b0; q_d_we = 1'b0; q_d_addr = '0; q_d_wdata = '0; q_d_type = TYPE_B;
        q_f_pend = 1'b0; q_f_pc = $urandom & 32'hFFFF_FFFC;
        c_lat = 0; c_rdata = '0; c_inst = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1;
        d_valid_i = 1'b0; f_valid_i = 1'b0; flush_i = 1'b0;
        ram_done_i = 1'b0; inst_ok_i = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One clock of randomized traffic: check registered outputs, move the
    // requesters and controller, check controller-facing outputs, advance model.
    task automatic cycle(input int d_pct, input int f_pct, input int fl_pct,
                         input int rdy_low_pct, input int spur_pct, input int lat_max);
        logic        exp_r, exp_w, exp_f;
        logic [31:0] ones;
        state_t      exp_st;
        chk("d_done_o", d_done_o, e_d_done);
        chk("f_ok_o", f_ok_o, e_f_ok);
        chk("d_rdata_o", d_rdata_o, e_d_rdata);
        chk("f_inst_o", f_inst_o, e_f_inst);
        chk("f_pc_o", f_pc_o, e_f_pc);
        if (measure) begin
            if (d_done_o) obs_dd++;
            if (f_ok_o) begin
                last_run = obs_dd;
                obs_dd = 0;
                n_fok++;
            end
        end
        if (d_fresh) begin
            d_fresh = 1'b0;
            q_d_pend = 1'b0;
            if (exp_q.size() > 0) chk("done_rdata", d_rdata_o, exp_q.pop_front());
        end
        if (f_fresh) begin
            f_fresh = 1'b0;
            q_f_pc = q_f_pc + 32'd4;
            q_f_pend = ($urandom_range(0, 99) < f_pct);
        end
        if (!q_d_pend && $urandom_range(0, 99) < d_pct) begin
            q_d_pend = 1'b1;
            q_d_we = ($urandom_range(0, 1) == 1) ? WRITE : READ;
            q_d_addr = $urandom;
            q_d_wdata = $urandom;
            case ($urandom_range(0, 2))
                0: q_d_type = TYPE_B;
                1: q_d_type = TYPE_H;
                default: q_d_type = TYPE_W;
            endcase
        end
        if (!q_f_pend && $urandom_range(0, 99) < f_pct) q_f_pend = 1'b1;
        flush_i = ($urandom_range(0, 99) < fl_pct);
        if (flush_i) q_f_pc = $urandom & 32'hFFFF_FFFC;

        ram_done_i = (m_txn == 1 && c_lat == 0);
        ram_data_i = c_rdata;
        inst_ok_i = (m_txn == 2 && c_lat == 0);
        inst_i = c_inst;
        inst_pc_i = m_pc;
        if (m_txn != 1 && $urandom_range(0, 99) < spur_pct) begin
            ram_done_i = 1'b1;
            ram_data_i = $urandom;
        end
        if (m_txn != 2 && $urandom_range(0, 99) < spur_pct) begin
            inst_ok_i = 1'b1;
            inst_i = $urandom;
            inst_pc_i = $urandom;
        end
        rdy = !($urandom_range(0, 99) < rdy_low_pct);
        d_valid_i = q_d_pend; d_we_i = q_d_we; d_addr_i = q_d_addr;
        d_wdata_i = q_d_wdata; d_type_i = q_d_type;
        f_valid_i = q_f_pend; f_pc_i = q_f_pc;
        #1;
        exp_r = (m_txn == 1) && (m_we == READ) && !ram_done_i;
        exp_w = (m_txn == 1) && (m_we == WRITE) && !ram_done_i;
        exp_f = (m_txn == 2) && !inst_ok_i;
        exp_st = (m_txn == 1) ? ST_DATA : ((m_txn == 2) ? ST_INST : ST_IDLE);
        chk("ram_r_req_o", ram_r_req_o, exp_r);
        chk("ram_w_req_o", ram_w_req_o, exp_w);
        chk("inst_fe_o", inst_fe_o, exp_f);
        chk("state", dbg_state, exp_st);
        ones = 32'(ram_r_req_o) + 32'(ram_w_req_o) + 32'(inst_fe_o);
        chk("req_exclusive", 32'(ones <= 32'd1), 32'd1);
        if (m_txn == 1) begin
            chk("ram_addr_o", ram_addr_o, m_addr);
            chk("ram_data_o", ram_data_o, m_wdata);
            chk("type_o", type_o, m_type);
        end
        if (m_txn == 2) chk("inst_fpc_o", inst_fpc_o, m_pc);

        if (rdy) begin
            e_d_done = 1'b0;
            e_f_ok = 1'b0;
            case (m_txn)
                0: begin
                    if (d_valid_i && (!f_valid_i || m_streak < LIMIT)) begin
                        m_we = d_we_i; m_addr = d_addr_i; m_wdata = d_wdata_i; m_type = d_type_i;
                        m_streak = f_valid_i ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
                        m_txn = 1;
                        c_lat = $urandom_range(0, lat_max);
                        c_rdata = $urandom;
                    end else if (f_valid_i && !flush_i) begin
                        m_pc = f_pc_i;
                        m_streak = 0;
                        m_stale = 1'b0;
                        m_txn = 2;
                        c_lat = $urandom_range(0, lat_max);
                        c_inst = $urandom;
                    end
                end
                1: begin
                    if (ram_done_i) begin
                        e_d_done = 1'b1;
                        d_fresh = 1'b1;
                        if (m_we == READ) e_d_rdata = ram_data_i;
                        exp_q.push_back(e_d_rdata);
                        m_txn = 0;
                    end else if (c_lat > 0) begin
                        c_lat--;
                    end
                end
                default: begin
                    if (flush_i) m_stale = 1'b1;
                    if (inst_ok_i) begin
                        if (!m_stale) begin
                            e_f_ok = 1'b1;
                            e_f_inst = inst_i;
                            e_f_pc = inst_pc_i;
                            f_fresh = 1'b1;
                        end
                        m_txn = 0;
                    end else if (c_lat > 0) begin
                        c_lat--;
                    end
                end
            endcase
        end
        tick();
    endtask

    initial begin
        model_reset();
        tick();
        do_reset();

        // reset state
        chk("rst_d_done", d_done_o, 0);
        chk("rst_f_ok", f_ok_o, 0);
        chk("rst_d_rdata", d_rdata_o, 0);
        chk("rst_f_inst", f_inst_o, 0);
        chk("rst_f_pc", f_pc_o, 0);
        chk("rst_r_req", ram_r_req_o, 0);
        chk("rst_w_req", ram_w_req_o, 0);
        chk("rst_fe", inst_fe_o, 0);
        chk("rst_fpc", inst_fpc_o, 0);
        chk("rst_state", dbg_state, ST_IDLE);

        // word read, 5 request cycles then done
        d_valid_i = 1'b1; d_we_i = READ; d_addr_i = 32'h100; d_type_i = TYPE_W;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("rd_req_hold", ram_r_req_o, 1);
            chk("rd_addr", ram_addr_o, 32'h100);
            chk("rd_type", type_o, TYPE_W);
            tick();
        end
        ram_done_i = 1'b1; ram_data_i = 32'hDEAD_BEEF;
        #1;
        chk("rd_req_gated", ram_r_req_o, 0);
        chk("rd_no_early_done", d_done_o, 0);
        tick();
        chk("rd_done", d_done_o, 1);
        chk("rd_data", d_rdata_o, 32'hDEAD_BEEF);
        ram_done_i = 1'b0; d_valid_i = 1'b0;
        tick();
        chk("rd_done_width", d_done_o, 0);
        chk("rd_data_hold", d_rdata_o, 32'hDEAD_BEEF);

        // simultaneous data write and fetch: data first, idle gap, then fetch
        d_valid_i = 1'b1; d_we_i = WRITE; d_addr_i = 32'h200; d_wdata_i = 32'h1122_3344; d_type_i = TYPE_B;
        f_valid_i = 1'b1; f_pc_i = 32'h400;
        tick();
        chk("both_w_req", ram_w_req_o, 1);
        chk("both_no_fe", inst_fe_o, 0);
        chk("both_wdata", ram_data_o, 32'h1122_3344);
        ram_done_i = 1'b1;
        tick();
        chk("wr_done", d_done_o, 1);
        chk("wr_keeps_rdata", d_rdata_o, 32'hDEAD_BEEF);
        ram_done_i = 1'b0; d_valid_i = 1'b0;
        #1;
        chk("gap_idle", dbg_state, ST_IDLE);
        chk("gap_no_fe", inst_fe_o, 0);
        tick();
        chk("fetch_fe", inst_fe_o, 1);
        chk("fetch_fpc", inst_fpc_o, 32'h400);
        inst_ok_i = 1'b1; inst_i = 32'h0000_0013; inst_pc_i = 32'h400;
        #1;
        chk("fetch_fe_gated", inst_fe_o, 0);
        tick();
        chk("fetch_ok", f_ok_o, 1);
        chk("fetch_inst", f_inst_o, 32'h0000_0013);
        chk("fetch_pc", f_pc_o, 32'h400);
        inst_ok_i = 1'b0; f_valid_i = 1'b0;
        tick();
        chk("fetch_ok_width", f_ok_o, 0);

        // flush while a fetch is in flight
        f_valid_i = 1'b1; f_pc_i = 32'h0;
        tick();
        chk("fl_fe", inst_fe_o, 1);
        chk("fl_fpc", inst_fpc_o, 32'h0);
        tick();
        flush_i = 1'b1; f_pc_i = 32'h80;
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_fpc_stable", inst_fpc_o, 32'h0);
        inst_ok_i = 1'b1; inst_i = 32'h0000_0013; inst_pc_i = 32'h0;
        tick();
        chk("fl_suppressed", f_ok_o, 0);
        chk("fl_idle", dbg_state, ST_IDLE);
        inst_ok_i = 1'b0;
        tick();
        chk("fl_refetch", inst_fe_o, 1);
        chk("fl_new_pc", inst_fpc_o, 32'h80);

        // reset in the middle of a fetch, with the completion arriving
        rst = 1'b1; inst_ok_i = 1'b1; inst_i = 32'hABCD_0001; inst_pc_i = 32'h80;
        tick();
        chk("rmid_state", dbg_state, ST_IDLE);
        chk("rmid_f_ok", f_ok_o, 0);
        chk("rmid_f_inst", f_inst_o, 0);
        chk("rmid_f_pc", f_pc_o, 0);
        chk("rmid_d_rdata", d_rdata_o, 0);
        chk("rmid_fpc", inst_fpc_o, 0);
        rst = 1'b0; inst_ok_i = 1'b0; f_valid_i = 1'b0;
        tick();
        chk("rmid_f_ok_after", f_ok_o, 0);

        // rdy low for 3 cycles with the completion held
        d_valid_i = 1'b1; d_we_i = READ; d_addr_i = 32'h300; d_type_i = TYPE_H;
        tick();
        ram_done_i = 1'b1; ram_data_i = 32'hCAFE_F00D; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_no_done", d_done_o, 0);
            chk("frz_state", dbg_state, ST_DATA);
            chk("frz_req_gated", ram_r_req_o, 0);
        end
        rdy = 1'b1;
        tick();
        chk("frz_done", d_done_o, 1);
        chk("frz_data", d_rdata_o, 32'hCAFE_F00D);
        ram_done_i = 1'b0; d_valid_i = 1'b0; rdy = 1'b0;
        tick();
        chk("frz_pulse_hold1", d_done_o, 1);
        tick();
        chk("frz_pulse_hold2", d_done_o, 1);
        rdy = 1'b1;
        tick();
        chk("frz_pulse_end", d_done_o, 0);
        chk("frz_end_state", dbg_state, ST_IDLE);

        // randomized mixed traffic
        do_reset();
        for (int i = 0; i < 800; i++) cycle(60, 50, 5, 10, 5, 5);
        for (int i = 0; i < 400; i++) cycle(90, 90, 10, 0, 0, 3);

        // back-to-back data with a fetch always pending
        do_reset();
        measure = 1'b1;
        for (int i = 0; i < 200; i++) cycle(100, 100, 0, 0, 0, 2);
        measure = 1'b0;
        chk("starve_fetch_seen", 32'(n_fok > 1), 1);
        chk("starve_run", last_run, LIMIT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
